// File: rtl/seg_scan_decoder.sv
// Watches a multiplexed 8-digit seven-segment scan and rebuilds the displayed frame:
// hex value per digit, blank and decimal-point masks, plus error flags for unknown glyphs.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  anode_activate,
    input  logic [7:0]  LED_out,
    output logic [31:0] value,
    output logic [7:0]  blank_mask,
    output logic [7:0]  dp_mask,
    output logic        frame_valid,
    output logic        pattern_err,
    output logic        frame_err
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t      state_q, state_d;
    logic [7:0]  refAnode_q, refAnode_d;
    logic [7:0]  refLed_q, refLed_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  mask_q, mask_d;
    logic [31:0] shadowVal_q, shadowVal_d;
    logic [7:0]  shadowBlank_q, shadowBlank_d;
    logic [7:0]  shadowDp_q, shadowDp_d;
    logic        shadowErr_q, shadowErr_d;
    logic [31:0] value_q, value_d;
    logic [7:0]  blank_q, blank_d;
    logic [7:0]  dp_q, dp_d;
    logic        frameValid_q, frameValid_d;
    logic        patternErr_q, patternErr_d;
    logic        frameErr_q, frameErr_d;

    logic        slotValid;
    logic [2:0]  slotIdx;
    logic [3:0]  zeroCnt;
    logic        matchRef;
    logic        capture;
    logic        publish;
    logic [5:0]  decoded;

    // Result is {undecodable, blank, nibble}.
    function automatic logic [5:0] decodeSeg(input logic [6:0] seg);
        case (seg)
            7'b0000001: return 6'h00;
            7'b1001111: return 6'h01;
            7'b0010010: return 6'h02;
            7'b0000110: return 6'h03;
            7'b1001100: return 6'h04;
            7'b0100100: return 6'h05;
            7'b0100000: return 6'h06;
            7'b0001111: return 6'h07;
            7'b0000000: return 6'h08;
            7'b0000100: return 6'h09;
            7'b0001000: return 6'h0A;
            7'b1100000: return 6'h0B;
            7'b0110001: return 6'h0C;
            7'b1000010: return 6'h0D;
            7'b0110000: return 6'h0E;
            7'b0111000: return 6'h0F;
            7'b1111111: return 6'b010000;
            default:    return 6'b100000;
        endcase
    endfunction

    always_comb begin
        zeroCnt = 4'd0;
        slotIdx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!anode_activate[i]) begin
                zeroCnt = zeroCnt + 4'd1;
                slotIdx = 3'(i);
            end
        end
        slotValid = (zeroCnt == 4'd1);
        matchRef  = (anode_activate == refAnode_q) && (LED_out == refLed_q);
        decoded   = decodeSeg(LED_out[6:0]);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        refAnode_d = refAnode_q;
        refLed_d   = refLed_q;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                if (slotValid) begin
                    refAnode_d = anode_activate;
                    refLed_d   = LED_out;
                    cnt_d      = 8'd1;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (matchRef) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == 8'(STABLE_CYCLES)) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end else if (slotValid) begin
                    refAnode_d = anode_activate;
                    refLed_d   = LED_out;
                    cnt_d      = 8'd1;
                end else begin
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (!matchRef) begin
                    if (slotValid) begin
                        refAnode_d = anode_activate;
                        refLed_d   = LED_out;
                        cnt_d      = 8'd1;
                        state_d    = SETTLE;
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    // A capture landing in the publish cycle is applied after the clear, so it starts the next frame.
    always_comb begin
        publish       = (mask_q == 8'hFF);
        mask_d        = publish ? 8'h00 : mask_q;
        shadowErr_d   = publish ? 1'b0 : shadowErr_q;
        shadowVal_d   = shadowVal_q;
        shadowBlank_d = shadowBlank_q;
        shadowDp_d    = shadowDp_q;
        value_d       = value_q;
        blank_d       = blank_q;
        dp_d          = dp_q;
        frameErr_d    = frameErr_q;
        frameValid_d  = publish;
        patternErr_d  = capture && decoded[5];
        if (publish) begin
            value_d    = shadowVal_q;
            blank_d    = shadowBlank_q;
            dp_d       = shadowDp_q;
            frameErr_d = shadowErr_q;
        end
        if (capture) begin
            mask_d[slotIdx]                  = 1'b1;
            shadowVal_d[{slotIdx, 2'b00} +: 4] = decoded[3:0];
            shadowBlank_d[slotIdx]           = decoded[4];
            shadowDp_d[slotIdx]              = ~LED_out[7];
            if (decoded[5]) begin
                shadowErr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            refAnode_q    <= 8'hFF;
            refLed_q      <= 8'hFF;
            cnt_q         <= 8'd0;
            mask_q        <= 8'h00;
            shadowVal_q   <= 32'h0;
            shadowBlank_q <= 8'h00;
            shadowDp_q    <= 8'h00;
            shadowErr_q   <= 1'b0;
            value_q       <= 32'h0;
            blank_q       <= 8'hFF;
            dp_q          <= 8'h00;
            frameValid_q  <= 1'b0;
            patternErr_q  <= 1'b0;
            frameErr_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            refAnode_q    <= refAnode_d;
            refLed_q      <= refLed_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            shadowVal_q   <= shadowVal_d;
            shadowBlank_q <= shadowBlank_d;
            shadowDp_q    <= shadowDp_d;
            shadowErr_q   <= shadowErr_d;
            value_q       <= value_d;
            blank_q       <= blank_d;
            dp_q          <= dp_d;
            frameValid_q  <= frameValid_d;
            patternErr_q  <= patternErr_d;
            frameErr_q    <= frameErr_d;
        end
    end

    assign value       = value_q;
    assign blank_mask  = blank_q;
    assign dp_mask     = dp_q;
    assign frame_valid = frameValid_q;
    assign pattern_err = patternErr_q;
    assign frame_err   = frameErr_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: drives hand-built scan sequences and
// compares the published frame and pulse counts against hand-computed values.
module tb_seg_scan_decoder;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  anode_activate;
    logic [7:0]  LED_out;
    logic [31:0] value;
    logic [7:0]  blank_mask;
    logic [7:0]  dp_mask;
    logic        frame_valid;
    logic        pattern_err;
    logic        frame_err;

    int checkCount = 0;
    int passCount  = 0;
    int fvCount    = 0;
    int peCount    = 0;
    int fvBase;
    int peBase;

    seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .anode_activate (anode_activate),
        .LED_out        (LED_out),
        .value          (value),
        .blank_mask     (blank_mask),
        .dp_mask        (dp_mask),
        .frame_valid    (frame_valid),
        .pattern_err    (pattern_err),
        .frame_err      (frame_err)
    );

    always #5 clock = ~clock;

    // Pulse outputs are counted mid-cycle so each one-cycle pulse is seen exactly once.
    always @(negedge clock) begin
        if (frame_valid) fvCount++;
        if (pattern_err) peCount++;
    end

    function automatic logic [6:0] segCode(input logic [3:0] h);
        case (h)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] led, input int cycles);
        @(negedge clock);
        anode_activate = ~(8'h01 << idx);
        LED_out        = led;
        repeat (cycles) @(posedge clock);
    endtask

    task automatic applyIdle(input int cycles);
        @(negedge clock);
        anode_activate = 8'hFF;
        LED_out        = 8'hFF;
        repeat (cycles) @(posedge clock);
    endtask

    task automatic applyReset();
        @(negedge clock);
        reset          = 1'b1;
        anode_activate = 8'hFF;
        LED_out        = 8'hFF;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Scans digits hi..lo of a hex word, dp dark, 10 cycles per digit.
    task automatic scanHex(input logic [31:0] hex, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            applyStimulus(i, {1'b1, segCode(hex[i*4 +: 4])}, 10);
        end
    endtask

    initial begin
        reset          = 1'b1;
        anode_activate = 8'hFF;
        LED_out        = 8'hFF;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset value", value, 32'h0);
        checkOutput("reset blank_mask", {24'h0, blank_mask}, 32'hFF);
        checkOutput("reset dp_mask", {24'h0, dp_mask}, 32'h0);
        checkOutput("reset frame_valid", {31'h0, frame_valid}, 32'h0);
        checkOutput("reset pattern_err", {31'h0, pattern_err}, 32'h0);
        checkOutput("reset frame_err", {31'h0, frame_err}, 32'h0);
        reset = 1'b0;

        // Clean "12345678" frame
        fvBase = fvCount; peBase = peCount;
        scanHex(32'h12345678, 7, 0);
        applyIdle(4);
        @(negedge clock);
        checkOutput("12345678 frame_valid count", 32'(fvCount - fvBase), 32'd1);
        checkOutput("12345678 value", value, 32'h12345678);
        checkOutput("12345678 blank_mask", {24'h0, blank_mask}, 32'h0);
        checkOutput("12345678 dp_mask", {24'h0, dp_mask}, 32'h0);
        checkOutput("12345678 frame_err", {31'h0, frame_err}, 32'h0);
        checkOutput("12345678 pattern_err count", 32'(peCount - peBase), 32'd0);

        // Undecodable glyph on digit 3
        fvBase = fvCount; peBase = peCount;
        scanHex(32'h12345678, 7, 4);
        applyStimulus(3, 8'b1_1101111, 10);
        scanHex(32'h12345678, 2, 0);
        applyIdle(4);
        @(negedge clock);
        checkOutput("bad glyph pattern_err count", 32'(peCount - peBase), 32'd1);
        checkOutput("bad glyph frame_err", {31'h0, frame_err}, 32'h1);
        checkOutput("bad glyph value", value, 32'h12340678);
        checkOutput("bad glyph frame_valid count", 32'(fvCount - fvBase), 32'd1);

        scanHex(32'h12345678, 7, 0);
        applyIdle(4);
        @(negedge clock);
        checkOutput("clean after bad frame_err", {31'h0, frame_err}, 32'h0);
        checkOutput("clean after bad value", value, 32'h12345678);

        // Two anodes low at once is never a slot
        fvBase = fvCount; peBase = peCount;
        @(negedge clock);
        anode_activate = 8'b1111_1100;
        LED_out        = 8'b1_1101111;
        repeat (20) @(posedge clock);
        applyIdle(4);
        @(negedge clock);
        checkOutput("multi-anode frame_valid count", 32'(fvCount - fvBase), 32'd0);
        checkOutput("multi-anode pattern_err count", 32'(peCount - peBase), 32'd0);
        checkOutput("multi-anode value", value, 32'h12345678);

        // All digits blank with dp lit
        for (int i = 7; i >= 0; i--) applyStimulus(i, 8'h7F, 10);
        applyIdle(4);
        @(negedge clock);
        checkOutput("blank value", value, 32'h0);
        checkOutput("blank blank_mask", {24'h0, blank_mask}, 32'hFF);
        checkOutput("blank dp_mask", {24'h0, dp_mask}, 32'hFF);
        checkOutput("blank frame_err", {31'h0, frame_err}, 32'h0);

        // Stability threshold: 3 cycles too short, 4 enough
        applyReset();
        fvBase = fvCount; peBase = peCount;
        scanHex(32'h12345678, 7, 1);
        applyStimulus(0, {1'b1, segCode(4'h5)}, 3);
        applyIdle(5);
        @(negedge clock);
        checkOutput("held 3 frame_valid count", 32'(fvCount - fvBase), 32'd0);
        applyStimulus(0, {1'b1, segCode(4'h5)}, 4);
        applyIdle(4);
        @(negedge clock);
        checkOutput("held 4 frame_valid count", 32'(fvCount - fvBase), 32'd1);
        checkOutput("held 4 value", value, 32'h12345675);
        checkOutput("held 4 pattern_err count", 32'(peCount - peBase), 32'd0);

        // Reset mid-frame discards partial captures
        for (int i = 0; i < 5; i++) applyStimulus(i, {1'b1, segCode(4'h8)}, 10);
        applyIdle(2);
        applyReset();
        @(negedge clock);
        checkOutput("mid-frame reset dp_mask", {24'h0, dp_mask}, 32'h0);
        checkOutput("mid-frame reset value", value, 32'h0);
        fvBase = fvCount;
        scanHex(32'hDEADBEEF, 7, 5);
        applyIdle(4);
        @(negedge clock);
        checkOutput("partial after reset frame_valid count", 32'(fvCount - fvBase), 32'd0);
        scanHex(32'hDEADBEEF, 4, 0);
        applyIdle(4);
        @(negedge clock);
        checkOutput("DEADBEEF frame_valid count", 32'(fvCount - fvBase), 32'd1);
        checkOutput("DEADBEEF value", value, 32'hDEADBEEF);
        checkOutput("DEADBEEF blank_mask", {24'h0, blank_mask}, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
